keypad_entry: RTL and testbench

//  Front-panel digit entry for the microwave timer. Synchronises and debounces the
//  raw 0-9 keypad and encodes one accepted key to BCD. Issues a single-cycle

---
 rtl/keypad_entry.sv | 147 ++++++++++++++
 tb/tb_keypad_entry.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_entry.sv
// Front-panel digit entry: synchronises and debounces a raw 0-9 keypad, encodes one
// accepted key to BCD and strobes it into the mm:ss timer chain with an active-low load.
//
// state     | meaning
// S_IDLE    | waiting for a single-key pattern on the synchronised keys
// S_DEBOUNCE| counting identical samples of the latched pattern
// S_LOAD    | one cycle; requests the registered loadn strobe and data update
// S_RELEASE | waiting for DEBOUNCE_CYCLES consecutive all-zero samples
module keypad_entry #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MAX_DIGITS      = 3
) (
  input  logic       clk,
  input  logic       clear,
  input  logic [9:0] keys,
  input  logic       entry_en,
  input  logic       entry_clr,
  output logic [3:0] data,
  output logic       loadn,
  output logic [1:0] digit_count,
  output logic       reject
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [1:0]       MAX_CNT  = 2'(MAX_DIGITS);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_LOAD     = 2'd2,
    S_RELEASE  = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [9:0]       key_meta, ks;
  logic [9:0]       pat, pat_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             ks_valid, deb_done, can_load;
  logic             load_req, reject_req;
  logic [3:0]       digit;

  always_ff @(posedge clk) begin
    if (clear) begin
      key_meta <= '0;
      ks       <= '0;
    end else begin
      key_meta <= keys;
      ks       <= key_meta;
    end
  end

  // exactly one bit set: nonzero and clearing the lowest set bit leaves nothing
  assign ks_valid = (ks != '0) && ((ks & (ks - 10'd1)) == '0);
  assign deb_done = (ks == pat) && (cnt == DEB_LAST);
  assign can_load = entry_en && (digit_count < MAX_CNT);

  always_ff @(posedge clk) begin
    if (clear) begin
      state <= S_IDLE;
      cnt   <= '0;
      pat   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      pat   <= pat_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pat_nxt   = pat;
    case (state)
      S_IDLE: begin
        if (ks_valid) begin
          state_nxt = S_DEBOUNCE;
          pat_nxt   = ks;
          cnt_nxt   = CNT_W'(1);
        end
      end
      S_DEBOUNCE: begin
        if (ks != pat) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else if (deb_done) begin
          state_nxt = can_load ? S_LOAD : S_RELEASE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_LOAD: begin
        state_nxt = S_RELEASE;
        cnt_nxt   = '0;
      end
      S_RELEASE: begin
        if (ks != '0) begin
          cnt_nxt = '0;
        end else if (cnt == REL_LAST) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    load_req   = (state == S_LOAD);
    reject_req = (state == S_DEBOUNCE) && deb_done && !can_load;
  end

  always_comb begin
    digit = '0;
    for (int i = 0; i < 10; i++) begin
      if (pat[i]) digit = 4'(i);
    end
  end

  // entry_clr overrides a coincident load for count/data, but the strobe still fires
  always_ff @(posedge clk) begin
    if (clear) begin
      loadn       <= 1'b1;
      reject      <= 1'b0;
      data        <= '0;
      digit_count <= '0;
    end else begin
      loadn  <= !load_req;
      reject <= reject_req;
      if (entry_clr) begin
        data        <= '0;
        digit_count <= '0;
      end else if (load_req) begin
        data <= digit;
        if (digit_count < MAX_CNT) digit_count <= digit_count + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry: directed scenarios plus random key traffic, every cycle
// compared against a run-length reference model of the entry rules.
module tb_keypad_entry;

  localparam int DEB  = 4;
  localparam int MAXD = 3;

  logic       clk = 1'b0;
  logic       clear = 1'b1;
  logic [9:0] keys = '0;
  logic       entry_en = 1'b1;
  logic       entry_clr = 1'b0;
  logic [3:0] data;
  logic       loadn;
  logic [1:0] digit_count;
  logic       reject;

  keypad_entry #(.DEBOUNCE_CYCLES(DEB), .MAX_DIGITS(MAXD)) dut (
    .clk(clk), .clear(clear), .keys(keys), .entry_en(entry_en), .entry_clr(entry_clr),
    .data(data), .loadn(loadn), .digit_count(digit_count), .reject(reject)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_load = 0;
  int n_rej = 0;
  bit chk_on = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int key_index(input logic [9:0] v);
    int r = 0;
    for (int i = 0; i < 10; i++) if (v[i]) r = i;
    return r;
  endfunction

  // reference model: counts runs of one identical single-key sample; a press is
  // decided on its DEB+1-th sample, then nothing counts until DEB zero samples in a row
  logic [9:0] m_k1, m_ks, m_prev;
  int         m_run, m_zero, m_digit;
  bit         m_pend, m_rel;
  int         exp_loadn, exp_reject, exp_data, exp_cnt;

  always @(posedge clk) begin
    if (clear) begin
      m_k1 = '0; m_ks = '0; m_prev = '0;
      m_run = 0; m_zero = 0; m_digit = 0; m_pend = 0; m_rel = 0;
      exp_loadn = 1; exp_reject = 0; exp_data = 0; exp_cnt = 0;
    end else begin
      exp_loadn = 1;
      exp_reject = 0;
      if (m_pend) begin
        exp_loadn = 0;
        m_pend = 0; m_rel = 1; m_zero = 0;
        exp_data = m_digit;
        if (exp_cnt < MAXD) exp_cnt++;
      end else if (m_rel) begin
        if (m_ks == '0) begin
          m_zero++;
          if (m_zero == DEB) begin m_rel = 0; m_run = 0; end
        end else begin
          m_zero = 0;
        end
      end else begin
        if (m_run > 0 && m_ks != m_prev) m_run = 0;
        else if ($countones(m_ks) == 1) begin m_run++; m_prev = m_ks; end
        if (m_run == DEB + 1) begin
          m_run = 0;
          if (entry_en && exp_cnt < MAXD) begin
            m_pend = 1; m_digit = key_index(m_prev);
          end else begin
            exp_reject = 1; m_rel = 1; m_zero = 0;
          end
        end
      end
      if (entry_clr) begin exp_cnt = 0; exp_data = 0; end
      m_ks = m_k1;
      m_k1 = keys;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("loadn", loadn, exp_loadn);
      check("reject", reject, exp_reject);
      check("data", data, exp_data);
      check("digit_count", digit_count, exp_cnt);
      if (!loadn) n_load++;
      if (reject) n_rej++;
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_clear();
    clear = 1'b1; keys = '0; entry_clr = 1'b0;
    step(1);
    clear = 1'b0;
  endtask

  task automatic press(input int k, input int hold, input int gap);
    keys = 10'(1 << k);
    step(hold);
    keys = '0;
    step(gap);
  endtask

  int l0, r0, low_at, low_n;

  initial begin
    step(1);
    chk_on = 1;
    clear = 1'b0;
    check("rst_loadn", loadn, 1);
    check("rst_count", digit_count, 0);

    // 1: key 5 held; strobe in the cycle after edge 7, once only
    do_clear();
    l0 = n_load; low_at = -1; low_n = 0;
    keys = 10'b00_0010_0000;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (!loadn) begin low_n++; low_at = i; end
    end
    check("t1_pulses", low_n, 1);
    check("t1_edge", low_at, 7);
    check("t1_data", data, 5);
    check("t1_count", digit_count, 1);
    keys = '0; step(10);

    // 2: three digits then a refused fourth
    do_clear();
    l0 = n_load; r0 = n_rej;
    press(1, 12, 12); check("t2_d1", data, 1);
    press(3, 12, 12); check("t2_d3", data, 3);
    press(0, 12, 12); check("t2_d0", data, 0);
    check("t2_loads", n_load - l0, 3);
    check("t2_count", digit_count, 3);
    l0 = n_load;
    press(7, 12, 12);
    check("t2_rej", n_rej - r0, 1);
    check("t2_noload", n_load - l0, 0);
    check("t2_data", data, 0);

    // 3: bounce then stable; then a too-short press
    do_clear();
    l0 = n_load; r0 = n_rej;
    keys = 10'(1 << 2); step(1);
    keys = '0;          step(1);
    keys = 10'(1 << 2); step(15);
    keys = '0;          step(10);
    check("t3_loads", n_load - l0, 1);
    check("t3_data", data, 2);
    l0 = n_load;
    press(6, DEB - 1, 12);
    check("t3_short_load", n_load - l0, 0);
    check("t3_short_rej", n_rej - r0, 0);

    // 4: two keys together are never a press
    do_clear();
    l0 = n_load; r0 = n_rej;
    keys = 10'b00_0001_1000; step(20);
    keys = '0; step(10);
    check("t4_multi_load", n_load - l0, 0);
    check("t4_multi_rej", n_rej - r0, 0);
    press(4, 12, 12);
    check("t4_data", data, 4);

    // 5: entry disabled, then entry_clr after two digits
    do_clear();
    l0 = n_load; r0 = n_rej;
    entry_en = 1'b0;
    press(9, 12, 12);
    entry_en = 1'b1;
    check("t5_rej", n_rej - r0, 1);
    check("t5_noload", n_load - l0, 0);
    press(1, 12, 12);
    press(2, 12, 12);
    entry_clr = 1'b1; step(1); entry_clr = 1'b0;
    check("t5_clr_count", digit_count, 0);
    check("t5_clr_data", data, 0);
    press(6, 12, 12);
    check("t5_after_count", digit_count, 1);
    check("t5_after_data", data, 6);

    // 6: clear during debounce and during the load cycle
    do_clear();
    l0 = n_load;
    keys = 10'(1 << 8); step(4);
    keys = '0; clear = 1'b1; step(1); clear = 1'b0;
    check("t6a_loadn", loadn, 1);
    check("t6a_count", digit_count, 0);
    step(15);
    keys = 10'(1 << 8); step(7);
    keys = '0; clear = 1'b1; step(1); clear = 1'b0;
    check("t6b_loadn", loadn, 1);
    step(15);
    check("t6_loads", n_load - l0, 0);
    check("t6_data", data, 0);

    // random traffic against the model
    for (int k = 0; k < 400; k++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 3) keys = '0;
      else if (r < 8) keys = 10'(1 << $urandom_range(0, 9));
      else keys = 10'((1 << $urandom_range(0, 9)) | (1 << $urandom_range(0, 9)));
      entry_en  = ($urandom_range(0, 7) != 0);
      entry_clr = ($urandom_range(0, 15) == 0);
      clear     = ($urandom_range(0, 63) == 0);
      step(1);
      entry_clr = 1'b0;
      clear = 1'b0;
      step($urandom_range(0, 10));
    end
    keys = '0;
    step(10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
